// File: rtl/idea_dec_keygen.sv
// IDEA decryption key-schedule generator: expands the 128-bit user key into the
// 52 encryption subkeys, then builds the 52 decryption subkeys into a readable table.
module idea_dec_keygen (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [5:0]   rd_addr,
  output logic [15:0]  rd_data
);

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned NUM_KEYS  = 52;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned ROT       = 25;
  localparam int unsigned MUL_STEPS = 30;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_CONVERT, S_DONE} state_t;

  // Multiplication mod 65537 with 0 standing for 65536 (low-high reduction).
  function automatic logic [WORD_W-1:0] idea_mul(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
    logic [2*WORD_W-1:0] p;
    logic [WORD_W-1:0]   lo;
    logic [WORD_W-1:0]   hi;
    p  = 32'(a) * 32'(b);
    lo = p[WORD_W-1:0];
    hi = p[2*WORD_W-1:WORD_W];
    if (a == '0)      idea_mul = 16'(16'd1 - b);
    else if (b == '0) idea_mul = 16'(16'd1 - a);
    else              idea_mul = 16'(lo - hi + {15'd0, lo < hi});
  endfunction

  logic [WORD_W-1:0] z_mem [NUM_KEYS];
  logic [WORD_W-1:0] d_mem [NUM_KEYS];

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        grp_q, grp_d;
  logic [2:0]        pos_q, pos_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        step_q, step_d;
  logic [WORD_W-1:0] r_q, r_d;
  logic [WORD_W-1:0] x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              key_valid_q, key_valid_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  logic              z_we, d_we, adv, swap, is_inv;
  logic [WORD_W-1:0] z_wdata, d_wdata, z_src, mul_b, mul_res;
  logic [ADDR_W-1:0] src_idx;

  // Source encryption subkey for decryption entry (grp, pos); middle rounds swap 2/3.
  always_comb begin
    src_idx = base_q;
    swap    = (grp_q != 4'd0) && (grp_q != 4'd8);
    is_inv  = (pos_q == 3'd0) || (pos_q == 3'd3);
    unique case (pos_q)
      3'd0:    src_idx = base_q;
      3'd1:    src_idx = base_q + (swap ? 6'd2 : 6'd1);
      3'd2:    src_idx = base_q + (swap ? 6'd1 : 6'd2);
      3'd3:    src_idx = base_q + 6'd3;
      3'd4:    src_idx = base_q - 6'd2;
      default: src_idx = base_q - 6'd1;
    endcase
    z_src   = z_mem[src_idx];
    mul_b   = step_q[0] ? r_q : x_q;
    mul_res = idea_mul(r_q, mul_b);
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    idx_d       = idx_q;
    grp_d       = grp_q;
    pos_d       = pos_q;
    base_d      = base_q;
    step_d      = step_q;
    r_d         = r_q;
    x_d         = x_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    z_we        = 1'b0;
    z_wdata     = key_q[{3'(3'd7 - idx_q[2:0]), 4'd0} +: WORD_W];
    d_we        = 1'b0;
    d_wdata     = '0;
    adv         = 1'b0;
    rd_data_d   = (rd_addr < ADDR_W'(NUM_KEYS)) ? d_mem[rd_addr] : '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_EXPAND;
          key_d       = key_in;
          idx_d       = '0;
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
        end
      end
      S_EXPAND: begin
        z_we = 1'b1;
        if (idx_q[2:0] == 3'd7)
          key_d = {key_q[KEY_W-ROT-1:0], key_q[KEY_W-1:KEY_W-ROT]};
        if (idx_q == ADDR_W'(NUM_KEYS - 1)) begin
          state_d = S_CONVERT;
          idx_d   = '0;
          grp_d   = '0;
          pos_d   = '0;
          base_d  = ADDR_W'(NUM_KEYS - 4);
          step_d  = '0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      S_CONVERT: begin
        if (is_inv) begin
          // Fermat inverse: load, then alternate square / multiply-by-x.
          if (step_q == 5'd0) begin
            r_d    = z_src;
            x_d    = z_src;
            step_d = 5'd1;
          end else begin
            r_d = mul_res;
            if (step_q == 5'(MUL_STEPS)) begin
              d_we    = 1'b1;
              d_wdata = mul_res;
              step_d  = '0;
              adv     = 1'b1;
            end else begin
              step_d = step_q + 5'd1;
            end
          end
        end else begin
          d_we    = 1'b1;
          d_wdata = (pos_q < 3'd4) ? 16'(16'd0 - z_src) : z_src;
          adv     = 1'b1;
        end
        if (adv) begin
          if (idx_q == ADDR_W'(NUM_KEYS - 1)) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            key_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
            if (pos_q == 3'd5) begin
              pos_d  = '0;
              grp_d  = grp_q + 4'd1;
              base_d = base_q - 6'd6;
            end else begin
              pos_d = pos_q + 3'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      idx_q       <= '0;
      grp_q       <= '0;
      pos_q       <= '0;
      base_q      <= '0;
      step_q      <= '0;
      r_q         <= '0;
      x_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      grp_q       <= grp_d;
      pos_q       <= pos_d;
      base_q      <= base_d;
      step_q      <= step_d;
      r_q         <= r_d;
      x_q         <= x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Subkey tables; contents are don't-care until a schedule completes.
  always_ff @(posedge clk) begin
    if (z_we && !rst) z_mem[idx_q] <= z_wdata;
    if (d_we && !rst) d_mem[idx_q] <= d_wdata;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_idea_dec_keygen.sv
// Directed bench for idea_dec_keygen: latency, reset abort, start handling and table contents.
module tb_idea_dec_keygen;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [5:0]   rd_addr;
  logic [15:0]  rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_SEQ  = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] KEY_ONES = {128{1'b1}};

  // Hand-derived entries for KEY_SEQ (Z9=0x0400, Z11=0x0800, Z12=0x0A00).
  int          seq_addr [11] = '{48, 49, 50, 51, 46, 47, 42, 43, 44, 40, 41};
  logic [15:0] seq_exp  [11] = '{16'h0001, 16'hFFFE, 16'hFFFD, 16'hC001, 16'h0005, 16'h0006,
                                 16'h4925, 16'hFC00, 16'hFFF8, 16'h0800, 16'h0A00};

  always #5 clk = ~clk;

  idea_dec_keygen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  function automatic logic [15:0] ones_exp(input int j);
    case (j % 6)
      0, 3:    return 16'h8000;
      1, 2:    return 16'h0001;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Launch one schedule; returns cycles from accept to done (-1 on timeout).
  task automatic run_keygen(input logic [127:0] k, output int cyc, output bit busy_ok);
    bit seen;
    seen    = 1'b0;
    busy_ok = 1'b1;
    cyc     = 0;
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    while (cyc < 2000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start  = 1'b0;
        key_in = ~k;
      end
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    if (!seen) cyc = -1;
  endtask

  task automatic read_word(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    key_in  = '0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_zero_key();
    int cyc; bit bok; logic [15:0] d;
    run_keygen('0, cyc, bok);
    n_cmp++; if (cyc != 645) begin n_bad++; $display("FAIL zero_latency got %0d want 645", cyc); end
    n_cmp++; if (!bok) begin n_bad++; $display("FAIL zero_busy got busy low before done want high"); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_at_done got %b want 0", busy); end
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL zero_key_valid got %b want 1", key_valid); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse got %b want 0", done); end
    for (int j = 0; j < 52; j++) begin
      read_word(6'(j), d);
      n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL zero_table[%0d] got %h want 0000", j, d); end
    end
  endtask

  task automatic test_all_ones();
    int cyc; bit bok; logic [15:0] d;
    run_keygen(KEY_ONES, cyc, bok);
    n_cmp++; if (cyc != 645) begin n_bad++; $display("FAIL ones_latency got %0d want 645", cyc); end
    for (int j = 0; j < 52; j++) begin
      read_word(6'(j), d);
      n_cmp++;
      if (d !== ones_exp(j)) begin
        n_bad++; $display("FAIL ones_table[%0d] got %h want %h", j, d, ones_exp(j));
      end
    end
  endtask

  task automatic test_known_key();
    int cyc; bit bok; logic [15:0] d;
    run_keygen(KEY_SEQ, cyc, bok);
    n_cmp++; if (cyc != 645) begin n_bad++; $display("FAIL seq_latency got %0d want 645", cyc); end
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL seq_key_valid got %b want 1", key_valid); end
    for (int i = 0; i < 11; i++) begin
      read_word(6'(seq_addr[i]), d);
      n_cmp++;
      if (d !== seq_exp[i]) begin
        n_bad++; $display("FAIL seq_table[%0d] got %h want %h", seq_addr[i], d, seq_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit bok; bit stray; logic [15:0] d;
    @(negedge clk);
    start  = 1'b1;
    key_in = KEY_SEQ;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL abort_key_valid got %b want 0", key_valid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b want 0", done); end
    rst   = 1'b0;
    stray = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_cmp++; if (stray) begin n_bad++; $display("FAIL abort_quiet got activity after abort want idle"); end
    run_keygen(KEY_SEQ, cyc, bok);
    n_cmp++; if (cyc != 645) begin n_bad++; $display("FAIL rerun_latency got %0d want 645", cyc); end
    for (int i = 0; i < 11; i++) begin
      read_word(6'(seq_addr[i]), d);
      n_cmp++;
      if (d !== seq_exp[i]) begin
        n_bad++; $display("FAIL rerun_table[%0d] got %h want %h", seq_addr[i], d, seq_exp[i]);
      end
    end
  endtask

  task automatic test_start_held();
    int nd, d1, d2;
    logic b646, b647, kv647;
    nd = 0; d1 = -1; d2 = -1;
    b646 = 1'bx; b647 = 1'bx; kv647 = 1'bx;
    @(negedge clk);
    start  = 1'b1;
    key_in = KEY_SEQ;
    @(posedge clk);
    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) d1 = k;
        else if (nd == 2) d2 = k;
      end
      if (k == 646) b646 = busy;
      if (k == 647) begin b647 = busy; kv647 = key_valid; end
      if (k == 700) start = 1'b0;
    end
    n_cmp++; if (nd != 2) begin n_bad++; $display("FAIL held_done_count got %0d want 2", nd); end
    n_cmp++; if (d1 != 645) begin n_bad++; $display("FAIL held_first_done got %0d want 645", d1); end
    n_cmp++; if (d2 != 1291) begin n_bad++; $display("FAIL held_second_done got %0d want 1291", d2); end
    n_cmp++; if (b646 !== 1'b0) begin n_bad++; $display("FAIL held_busy_t646 got %b want 0", b646); end
    n_cmp++; if (b647 !== 1'b1) begin n_bad++; $display("FAIL held_busy_t647 got %b want 1", b647); end
    n_cmp++; if (kv647 !== 1'b0) begin n_bad++; $display("FAIL held_key_valid_t647 got %b want 0", kv647); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok;
    logic [5:0]  last_addr;
    logic [15:0] want;
    run_keygen(KEY_ONES, cyc, bok);
    n_cmp++; if (cyc != 645) begin n_bad++; $display("FAIL b2b_latency got %0d want 645", cyc); end
    @(negedge clk);
    rd_addr   = 6'd0;
    last_addr = 6'd0;
    for (int n = 1; n <= 53; n++) begin
      @(negedge clk);
      want = (last_addr < 6'd52) ? ones_exp(int'(last_addr)) : 16'h0000;
      n_cmp++;
      if (rd_data !== want) begin
        n_bad++; $display("FAIL b2b_read[%0d] got %h want %h", last_addr, rd_data, want);
      end
      if (n <= 51) rd_addr = 6'(n);
      else if (n == 52) rd_addr = 6'd60;
      last_addr = rd_addr;
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_all_ones();
    test_known_key();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
